// File: rtl/quadrature_decoder_pkg.sv
// Shared phase/direction constants and the transition classifier for the quadrature decoder.
package quadrature_decoder_pkg;

  localparam logic [1:0] PHASE_00 = 2'b00;
  localparam logic [1:0] PHASE_10 = 2'b10;
  localparam logic [1:0] PHASE_11 = 2'b11;
  localparam logic [1:0] PHASE_01 = 2'b01;

  localparam logic DIR_FORWARD = 1'b1;
  localparam logic DIR_REVERSE = 1'b0;

  typedef enum logic [1:0] {
    STEP_NONE    = 2'd0,
    STEP_FWD     = 2'd1,
    STEP_REV     = 2'd2,
    STEP_ILLEGAL = 2'd3
  } step_kind_e;

  // Forward order is 00 -> 10 -> 11 -> 01 -> 00; any other single-bit change is reverse.
  function automatic step_kind_e classify_step(input logic [1:0] prev, input logic [1:0] cur);
    logic [1:0] fwd_next;
    case (prev)
      PHASE_10: fwd_next = PHASE_11;
      PHASE_11: fwd_next = PHASE_01;
      PHASE_01: fwd_next = PHASE_00;
      default:  fwd_next = PHASE_10;
    endcase
    if (cur == prev) return STEP_NONE;
    if ((cur ^ prev) == 2'b11) return STEP_ILLEGAL;
    if (cur == fwd_next) return STEP_FWD;
    return STEP_REV;
  endfunction

endpackage

// File: rtl/input_glitch_filter.sv
// Two-flop synchronizer followed by a stability counter; the output only follows
// the input after it has held steady long enough.
module input_glitch_filter #(
  parameter int unsigned FILTER_CYCLES    = 4,
  parameter int unsigned FILTER_BIT_WIDTH = 3
) (
  input  logic Clk,
  input  logic ResetN,
  input  logic Din,
  output logic Dout,
  output logic Settled
);

  localparam logic [FILTER_BIT_WIDTH-1:0] CNT_MAX    = '1;
  localparam logic [FILTER_BIT_WIDTH-1:0] CNT_ACCEPT = FILTER_BIT_WIDTH'(FILTER_CYCLES - 1);

  logic                        sync1;
  logic                        sync2;
  logic [FILTER_BIT_WIDTH-1:0] stable_cnt;

  // sync2 is the synchronized value, compared against the sample one stage earlier
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      sync1      <= 1'b0;
      sync2      <= 1'b0;
      stable_cnt <= '0;
      Dout       <= 1'b0;
      Settled    <= 1'b0;
    end else begin
      sync1 <= Din;
      sync2 <= sync1;
      if (sync1 != sync2) begin
        stable_cnt <= '0;
      end else if (stable_cnt != CNT_MAX) begin
        stable_cnt <= stable_cnt + FILTER_BIT_WIDTH'(1);
      end
      if (stable_cnt == CNT_ACCEPT) begin
        Settled <= 1'b1;
        if (sync2 != Dout) Dout <= sync2;
      end
    end
  end

endmodule

// File: rtl/quadrature_decoder.sv
// 4x quadrature decoder: filtered A/B phases drive step pulses, direction,
// a saturating position count and a sticky illegal-transition flag.
module quadrature_decoder
  import quadrature_decoder_pkg::*;
#(
  parameter int unsigned POSITION_BIT_WIDTH = 8,
  parameter int unsigned MAX_VALUE          = 2**POSITION_BIT_WIDTH - 1,
  parameter int unsigned MIN_VALUE          = 0,
  parameter int unsigned FILTER_CYCLES      = 4,
  parameter int unsigned FILTER_BIT_WIDTH   = 3
) (
  input  logic                          Clk,
  input  logic                          ResetN,
  input  logic                          EncA,
  input  logic                          EncB,
  input  logic                          Clear,
  output logic [POSITION_BIT_WIDTH-1:0] Position,
  output logic                          StepPulse,
  output logic                          StepDir,
  output logic                          LimitReachedFlag,
  output logic                          ErrorFlag
);

  localparam logic [POSITION_BIT_WIDTH-1:0] POS_MAX = POSITION_BIT_WIDTH'(MAX_VALUE);
  localparam logic [POSITION_BIT_WIDTH-1:0] POS_MIN = POSITION_BIT_WIDTH'(MIN_VALUE);

  logic       filt_a;
  logic       filt_b;
  logic       settled_a;
  logic       settled_b;
  logic [1:0] phase_cur;
  logic [1:0] phase_prev;
  logic       primed;
  step_kind_e step_kind;

  input_glitch_filter #(
    .FILTER_CYCLES   (FILTER_CYCLES),
    .FILTER_BIT_WIDTH(FILTER_BIT_WIDTH)
  ) u_filter_a (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Din    (EncA),
    .Dout   (filt_a),
    .Settled(settled_a)
  );

  input_glitch_filter #(
    .FILTER_CYCLES   (FILTER_CYCLES),
    .FILTER_BIT_WIDTH(FILTER_BIT_WIDTH)
  ) u_filter_b (
    .Clk    (Clk),
    .ResetN (ResetN),
    .Din    (EncB),
    .Dout   (filt_b),
    .Settled(settled_b)
  );

  assign phase_cur = {filt_a, filt_b};

  always_comb begin
    step_kind = classify_step(phase_prev, phase_cur);
  end

  // Until primed, phase changes only seed the tracker so a non-00 rest phase is not counted
  always_ff @(posedge Clk or negedge ResetN) begin
    if (!ResetN) begin
      phase_prev       <= PHASE_00;
      primed           <= 1'b0;
      Position         <= POS_MIN;
      StepPulse        <= 1'b0;
      StepDir          <= 1'b0;
      LimitReachedFlag <= 1'b0;
      ErrorFlag        <= 1'b0;
    end else begin
      StepPulse  <= 1'b0;
      phase_prev <= phase_cur;
      if (!primed) begin
        primed <= (settled_a & settled_b) | (step_kind != STEP_NONE);
      end else begin
        case (step_kind)
          STEP_FWD: begin
            StepPulse <= 1'b1;
            StepDir   <= DIR_FORWARD;
            if (Position < POS_MAX) begin
              Position         <= Position + POSITION_BIT_WIDTH'(1);
              LimitReachedFlag <= 1'b0;
            end else begin
              LimitReachedFlag <= 1'b1;
            end
          end
          STEP_REV: begin
            StepPulse <= 1'b1;
            StepDir   <= DIR_REVERSE;
            if (Position > POS_MIN) begin
              Position         <= Position - POSITION_BIT_WIDTH'(1);
              LimitReachedFlag <= 1'b0;
            end else begin
              LimitReachedFlag <= 1'b1;
            end
          end
          STEP_ILLEGAL: ErrorFlag <= 1'b1;
          default: ;
        endcase
      end
      // Clear overrides any count/flag update made this cycle; StepPulse/StepDir still report
      if (Clear) begin
        Position         <= POS_MIN;
        LimitReachedFlag <= 1'b0;
        ErrorFlag        <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_quadrature_decoder.sv
// Bench for quadrature_decoder: an 8-bit and a 4-bit position instance share the
// same encoder stimulus and are checked against a phase-index reference model.
module tb_quadrature_decoder;

  logic       Clk;
  logic       ResetN;
  logic       EncA;
  logic       EncB;
  logic       Clear;
  logic [7:0] pos8;
  logic [3:0] pos4;
  logic       pulse8, pulse4;
  logic       dir8, dir4;
  logic       lim8, lim4;
  logic       err8, err4;

  int total = 0;
  int bad   = 0;

  // Reference model state
  logic [1:0] order [4] = '{2'b00, 2'b10, 2'b11, 2'b01};
  logic [1:0] m_phase;
  bit         m_primed;
  int         m_pos8, m_pos4;
  bit         m_lim8, m_lim4, m_err, m_dir;

  quadrature_decoder u_dut8 (
    .Clk(Clk), .ResetN(ResetN), .EncA(EncA), .EncB(EncB), .Clear(Clear),
    .Position(pos8), .StepPulse(pulse8), .StepDir(dir8),
    .LimitReachedFlag(lim8), .ErrorFlag(err8)
  );

  quadrature_decoder #(.POSITION_BIT_WIDTH(4)) u_dut4 (
    .Clk(Clk), .ResetN(ResetN), .EncA(EncA), .EncB(EncB), .Clear(Clear),
    .Position(pos4), .StepPulse(pulse4), .StepDir(dir4),
    .LimitReachedFlag(lim4), .ErrorFlag(err4)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  function automatic int idx_of(input logic [1:0] p);
    for (int i = 0; i < 4; i++) if (order[i] == p) return i;
    return 0;
  endfunction

  function automatic logic [1:0] fwd_of(input logic [1:0] p);
    return order[(idx_of(p) + 1) % 4];
  endfunction

  function automatic logic [1:0] rev_of(input logic [1:0] p);
    return order[(idx_of(p) + 3) % 4];
  endfunction

  task automatic model_reset();
    m_phase = 2'b00; m_primed = 0;
    m_pos8 = 0; m_pos4 = 0; m_lim8 = 0; m_lim4 = 0; m_err = 0; m_dir = 0;
  endtask

  // Apply one filtered phase change to the model; reports whether a step pulse is due
  task automatic model_change(input logic [1:0] np, output bit pulse);
    int d;
    pulse = 0;
    if (np == m_phase) return;
    if (!m_primed) begin
      m_primed = 1; m_phase = np; return;
    end
    d = (idx_of(np) - idx_of(m_phase) + 4) % 4;
    m_phase = np;
    if (d == 2) begin
      m_err = 1; return;
    end
    pulse = 1;
    m_dir = (d == 1);
    if (m_dir) begin
      if (m_pos8 < 255) begin m_pos8++; m_lim8 = 0; end else m_lim8 = 1;
      if (m_pos4 < 15)  begin m_pos4++; m_lim4 = 0; end else m_lim4 = 1;
    end else begin
      if (m_pos8 > 0) begin m_pos8--; m_lim8 = 0; end else m_lim8 = 1;
      if (m_pos4 > 0) begin m_pos4--; m_lim4 = 0; end else m_lim4 = 1;
    end
  endtask

  // Drive a new phase, watch 12 edges, compare pulse count/latency and final state
  task automatic move(input logic [1:0] np, input string tag);
    bit exp_pulse;
    int n8 = 0, n4 = 0, first8 = -1;
    model_change(np, exp_pulse);
    EncA = np[1]; EncB = np[0];
    for (int e = 0; e < 12; e++) begin
      @(posedge Clk); #1;
      if (pulse8) begin n8++; if (first8 < 0) first8 = e; end
      if (pulse4) n4++;
    end
    total++; if (n8 !== int'(exp_pulse)) begin bad++; $display("FAIL %s pulses8 got=%0d exp=%0d", tag, n8, exp_pulse); end
    total++; if (n4 !== int'(exp_pulse)) begin bad++; $display("FAIL %s pulses4 got=%0d exp=%0d", tag, n4, exp_pulse); end
    if (exp_pulse) begin
      total++; if (first8 !== 6) begin bad++; $display("FAIL %s latency got=%0d exp=6", tag, first8); end
    end
    total++; if (pos8 !== 8'(m_pos8)) begin bad++; $display("FAIL %s pos8 got=%0d exp=%0d", tag, pos8, m_pos8); end
    total++; if (pos4 !== 4'(m_pos4)) begin bad++; $display("FAIL %s pos4 got=%0d exp=%0d", tag, pos4, m_pos4); end
    total++; if (lim8 !== m_lim8 || lim4 !== m_lim4) begin bad++; $display("FAIL %s limit got=%b/%b exp=%b/%b", tag, lim8, lim4, m_lim8, m_lim4); end
    total++; if (dir8 !== m_dir || dir4 !== m_dir) begin bad++; $display("FAIL %s dir got=%b/%b exp=%b", tag, dir8, dir4, m_dir); end
    total++; if (err8 !== m_err || err4 !== m_err) begin bad++; $display("FAIL %s error got=%b/%b exp=%b", tag, err8, err4, m_err); end
  endtask

  // Toggle one phase for len cycles and put it back
  task automatic glitch(input bit on_a, input int len, input string tag);
    logic [1:0] orig, np;
    bit p1, p2;
    int n8 = 0, n4 = 0, exp_n;
    orig = m_phase;
    np   = orig ^ (on_a ? 2'b10 : 2'b01);
    p1 = 0; p2 = 0;
    if (len >= 4) begin
      model_change(np, p1);
      model_change(orig, p2);
    end
    exp_n = int'(p1) + int'(p2);
    EncA = np[1]; EncB = np[0];
    for (int e = 0; e < 20; e++) begin
      @(posedge Clk); #1;
      if (e == len - 1) begin EncA = orig[1]; EncB = orig[0]; end
      if (pulse8) n8++;
      if (pulse4) n4++;
    end
    total++; if (n8 !== exp_n || n4 !== exp_n) begin bad++; $display("FAIL %s len=%0d pulses got=%0d/%0d exp=%0d", tag, len, n8, n4, exp_n); end
    total++; if (pos8 !== 8'(m_pos8) || pos4 !== 4'(m_pos4)) begin bad++; $display("FAIL %s pos got=%0d/%0d exp=%0d/%0d", tag, pos8, pos4, m_pos8, m_pos4); end
    total++; if (dir8 !== m_dir || lim8 !== m_lim8 || lim4 !== m_lim4) begin bad++; $display("FAIL %s dir/lim got=%b/%b/%b exp=%b/%b/%b", tag, dir8, lim8, lim4, m_dir, m_lim8, m_lim4); end
  endtask

  task automatic do_clear(input string tag);
    Clear = 1'b1;
    @(posedge Clk); #1;
    Clear = 1'b0;
    m_pos8 = 0; m_pos4 = 0; m_lim8 = 0; m_lim4 = 0; m_err = 0;
    total++; if (pos8 !== 8'd0 || pos4 !== 4'd0) begin bad++; $display("FAIL %s pos got=%0d/%0d exp=0", tag, pos8, pos4); end
    total++; if (lim8 !== 1'b0 || lim4 !== 1'b0 || err8 !== 1'b0 || err4 !== 1'b0) begin bad++; $display("FAIL %s flags got=%b%b%b%b exp=0000", tag, lim8, lim4, err8, err4); end
  endtask

  task automatic test_reset();
    int n = 0;
    ResetN = 1'b0; Clear = 1'b0; EncA = 1'b0; EncB = 1'b0;
    model_reset();
    for (int i = 0; i < 8; i++) begin
      @(posedge Clk); #1;
      EncA = 1'($urandom); EncB = 1'($urandom);
    end
    total++; if ({pos8, pulse8, dir8, lim8, err8} !== 12'd0) begin bad++; $display("FAIL reset_hold dut8 got=%h exp=0", {pos8, pulse8, dir8, lim8, err8}); end
    total++; if ({pos4, pulse4, dir4, lim4, err4} !== 8'd0) begin bad++; $display("FAIL reset_hold dut4 got=%h exp=0", {pos4, pulse4, dir4, lim4, err4}); end
    EncA = 1'b0; EncB = 1'b0;
    @(posedge Clk); #1;
    ResetN = 1'b1;
    for (int e = 1; e <= 12; e++) begin
      @(posedge Clk); #1;
      if (pulse8 || pulse4) n++;
      if (e == 4) begin
        total++; if (u_dut8.primed !== 1'b0) begin bad++; $display("FAIL primed_early got=%b exp=0", u_dut8.primed); end
      end
      if (e == 5) begin
        total++; if (u_dut8.primed !== 1'b1) begin bad++; $display("FAIL primed_at5 got=%b exp=1", u_dut8.primed); end
      end
    end
    total++; if (n !== 0) begin bad++; $display("FAIL reset_release pulses got=%0d exp=0", n); end
    m_primed = 1;
  endtask

  task automatic test_forward();
    for (int i = 0; i < 16; i++) move(fwd_of(m_phase), "forward");
  endtask

  task automatic test_limits();
    move(rev_of(m_phase), "limit_rev");
    do_clear("limit_clear");
    move(rev_of(m_phase), "limit_rev_at_min");
  endtask

  task automatic test_glitch();
    glitch(1'b1, 3, "glitch_short");
    glitch(1'b1, 4, "glitch_accept");
  endtask

  task automatic test_illegal();
    move(m_phase ^ 2'b11, "illegal");
    move(fwd_of(m_phase), "after_illegal");
    do_clear("illegal_clear");
  endtask

  task automatic test_random();
    int r;
    for (int i = 0; i < 40; i++) begin
      r = $urandom_range(0, 9);
      if (r <= 3)      move(fwd_of(m_phase), "rand_fwd");
      else if (r <= 6) move(rev_of(m_phase), "rand_rev");
      else if (r == 7) glitch(1'($urandom), $urandom_range(1, 5), "rand_glitch");
      else if (r == 8) move(m_phase ^ 2'b11, "rand_illegal");
      else             do_clear("rand_clear");
    end
  endtask

  task automatic test_reset_mid();
    logic [1:0] np;
    int n = 0;
    move(fwd_of(m_phase), "pre_reset");
    move(fwd_of(m_phase), "pre_reset");
    np = fwd_of(m_phase);
    EncA = np[1]; EncB = np[0];
    repeat (3) @(posedge Clk);
    #2 ResetN = 1'b0;
    #1;
    total++; if ({pos8, pulse8, dir8, lim8, err8} !== 12'd0) begin bad++; $display("FAIL reset_mid dut8 got=%h exp=0", {pos8, pulse8, dir8, lim8, err8}); end
    total++; if ({pos4, pulse4, dir4, lim4, err4} !== 8'd0) begin bad++; $display("FAIL reset_mid dut4 got=%h exp=0", {pos4, pulse4, dir4, lim4, err4}); end
    EncA = 1'b1; EncB = 1'b1;
    model_reset();
    repeat (3) @(posedge Clk);
    #1 ResetN = 1'b1;
    for (int e = 0; e < 20; e++) begin
      @(posedge Clk); #1;
      if (pulse8 || pulse4) n++;
    end
    total++; if (n !== 0) begin bad++; $display("FAIL prime_11 pulses got=%0d exp=0", n); end
    total++; if (err8 !== 1'b0 || pos8 !== 8'd0) begin bad++; $display("FAIL prime_11 err/pos got=%b/%0d exp=0/0", err8, pos8); end
    m_phase = 2'b11; m_primed = 1;
    move(2'b01, "first_after_prime");
  endtask

  initial begin
    test_reset();
    test_forward();
    test_limits();
    test_glitch();
    test_illegal();
    test_random();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
